// File: rtl/traffic_phase_timer_if.sv
// Configuration bus for the traffic phase timer: duration-table writes in,
// pending-commit status out.
interface traffic_phase_timer_if #(
    parameter int CNT_W = 8
);
    logic             Cfg_we;
    logic [1:0]       Cfg_addr;
    logic [CNT_W-1:0] Cfg_wdata;
    logic             Cfg_pending;

    modport master (output Cfg_we, Cfg_addr, Cfg_wdata, input Cfg_pending);
    modport slave  (input Cfg_we, Cfg_addr, Cfg_wdata, output Cfg_pending);
endinterface

// File: rtl/traffic_phase_timer.sv
// Phase-duration scheduler for a one-hot 4-state intersection FSM: times each phase,
// reports expiry, extends EW green for pedestrians and commits table edits at S0 entry.
module traffic_phase_timer #(
    parameter int CNT_W    = 8,
    parameter int TICK_DIV = 16,
    parameter int GRN_NS_D = 30,
    parameter int YEL_NS_D = 4,
    parameter int GRN_EW_D = 20,
    parameter int YEL_EW_D = 4,
    parameter int PED_EXT  = 10
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [3:0]            State_cnt,
    input  logic                  Ped_req_EW,
    traffic_phase_timer_if.slave  cfg,
    output logic                  Done_NS,
    output logic                  Done_EW,
    output logic                  Ped_pending,
    output logic                  Fault
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [3:0] S0 = 4'b0001;
    localparam logic [3:0] S1 = 4'b0010;
    localparam logic [3:0] S2 = 4'b0100;
    localparam logic [3:0] S3 = 4'b1000;

    typedef enum logic [1:0] {
        IDX_GRN_NS = 2'd0,
        IDX_YEL_NS = 2'd1,
        IDX_GRN_EW = 2'd2,
        IDX_YEL_EW = 2'd3
    } tbl_idx_e;

    typedef logic [3:0][CNT_W-1:0] dur_tbl_t;

    localparam dur_tbl_t DUR_RST = {CNT_W'(YEL_EW_D), CNT_W'(GRN_EW_D),
                                    CNT_W'(YEL_NS_D), CNT_W'(GRN_NS_D)};
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic [3:0]         prev_state_q, prev_state_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic [PRESC_W-1:0] presc_q,      presc_d;
    dur_tbl_t           shadow_q,     shadow_d;
    dur_tbl_t           active_q,     active_d;
    logic               ped_q,        ped_d;
    logic               fault_q,      fault_d;

    logic               legal;
    logic               chg;
    logic               tick;
    logic [CNT_W-1:0]   base_dur;
    logic [31:0]        ext_sum;
    logic [CNT_W-1:0]   reload_dur;

    // NOTE: every variable assigned here gets a default first so no path infers a latch.
    always_comb begin
        legal = (State_cnt != 4'd0) && ((State_cnt & (State_cnt - 4'd1)) == 4'd0);
        chg   = (State_cnt != prev_state_q);
        tick  = (presc_q == PRESC_W'(TICK_DIV - 1));

        // S0 reads the shadow copy because that reload is also the commit point.
        case (State_cnt)
            S0:      base_dur = shadow_q[IDX_GRN_NS];
            S1:      base_dur = active_q[IDX_YEL_NS];
            S2:      base_dur = active_q[IDX_GRN_EW];
            S3:      base_dur = active_q[IDX_YEL_EW];
            default: base_dur = '0;
        endcase

        ext_sum = 32'(base_dur);
        if ((State_cnt == S2) && (ped_q || Ped_req_EW)) begin
            ext_sum = ext_sum + 32'(PED_EXT);
        end
        if (ext_sum > CNT_MAX) begin
            ext_sum = CNT_MAX;
        end
        reload_dur = (ext_sum == 32'd0) ? CNT_W'(1) : ext_sum[CNT_W-1:0];

        prev_state_d = State_cnt;
        cnt_d        = cnt_q;
        presc_d      = presc_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        ped_d        = ped_q;
        fault_d      = fault_q;

        if (!legal) begin
            fault_d = 1'b1;
        end else if (chg) begin
            cnt_d   = reload_dur;
            presc_d = '0;
            if (State_cnt == S0) begin
                active_d = shadow_q;
            end
        end else begin
            presc_d = tick ? '0 : presc_q + PRESC_W'(1);
            if (tick && (cnt_q != '0)) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        if (cfg.Cfg_we) begin
            shadow_d[cfg.Cfg_addr] = cfg.Cfg_wdata;
        end

        // Serving the request wins over a new request arriving in the same cycle.
        if (legal && chg && (State_cnt == S2)) begin
            ped_d = 1'b0;
        end else if (Ped_req_EW) begin
            ped_d = 1'b1;
        end
    end

    // NOTE: the duration tables are reset like ordinary flops because their reset contents
    // are the operating defaults, not don't-cares.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            prev_state_q <= 4'd0;
            cnt_q        <= '0;
            presc_q      <= '0;
            shadow_q     <= DUR_RST;
            active_q     <= DUR_RST;
            ped_q        <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of the others.
            prev_state_q <= prev_state_d;
            cnt_q        <= cnt_d;
            presc_q      <= presc_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            ped_q        <= ped_d;
            fault_q      <= fault_d;
        end
    end

    assign Done_NS = Reset_n && legal && !chg && (cnt_q == '0) && (State_cnt[0] || State_cnt[1]);
    assign Done_EW = Reset_n && legal && !chg && (cnt_q == '0) && (State_cnt[2] || State_cnt[3]);

    assign Ped_pending     = ped_q;
    assign Fault           = fault_q;
    assign cfg.Cfg_pending = (shadow_q != active_q);

endmodule
